freq_select_conditioner: RTL and testbench

//  Upstream stage of the PWM modulator. Conditions the raw frequency-select slide switch:

---
 rtl/freq_select_conditioner.sv | 128 ++++++++++++
 tb/tb_freq_select_conditioner.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/freq_select_conditioner.sv
// rtl/freq_select_conditioner.sv - synchronise, debounce and period-align the frequency-select switch
// Optional FREQ_SEL_TOGGLE_EN: treat sw_i as a push-button that toggles the selection.
module freq_select_conditioner #(
  parameter int sync_stages_p     = 2,
  parameter int debounce_cycles_p = 1000000,
  parameter int timeout_cycles_p  = 2**26,
  parameter int div_width_p       = 32,
  parameter logic [div_width_p-1:0] div_low_p  = div_width_p'(389120),
  parameter logic [div_width_p-1:0] div_high_p = div_width_p'(110592)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   sw_i,
  input  logic                   period_end_i,
  output logic [div_width_p-1:0] div_factor_o,
  output logic                   freq_sel_o,
  output logic                   load_o,
  output logic                   busy_o
);

  localparam int cnt_w_lp = (debounce_cycles_p > 1) ? $clog2(debounce_cycles_p) : 1;
  localparam int tmo_w_lp = (timeout_cycles_p > 1) ? $clog2(timeout_cycles_p) : 1;
  localparam logic [cnt_w_lp-1:0] cnt_last_lp = cnt_w_lp'(debounce_cycles_p - 1);
  localparam logic [tmo_w_lp-1:0] tmo_last_lp = tmo_w_lp'(timeout_cycles_p - 1);

  typedef enum logic [0:0] {IDLE, WAIT} state_t;

  logic [sync_stages_p-1:0] sync_q;
  logic                     sw_s;
  logic [cnt_w_lp-1:0]      cnt_q;
  logic                     stable_q;
  logic                     accept;
  logic                     target;

  state_t                   state_q, state_d;
  logic [tmo_w_lp-1:0]      tmo_q, tmo_d;
  logic                     busy_d, load_d, sel_d;
  logic [div_width_p-1:0]   div_d;

  always_ff @(posedge clk) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[sync_stages_p-2:0], sw_i};
  end

  assign sw_s   = sync_q[sync_stages_p-1];
  assign accept = (sw_s != stable_q) && (cnt_q == cnt_last_lp);

  // Counter only runs while the synchronised level disagrees with the accepted one.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      stable_q <= 1'b0;
    end else if (sw_s == stable_q) begin
      cnt_q    <= '0;
    end else if (accept) begin
      cnt_q    <= '0;
      stable_q <= sw_s;
    end else begin
      cnt_q    <= cnt_q + 1'b1;
    end
  end

`ifdef FREQ_SEL_TOGGLE_EN
  logic toggle_q;

  // A rising debounced edge is an accept while the new level is 1.
  always_ff @(posedge clk) begin
    if (rst)                toggle_q <= 1'b0;
    else if (accept && sw_s) toggle_q <= ~toggle_q;
  end

  assign target = toggle_q;
`else
  assign target = stable_q;
`endif

  always_comb begin
    state_d = state_q;
    tmo_d   = tmo_q;
    busy_d  = busy_o;
    load_d  = 1'b0;
    sel_d   = freq_sel_o;
    div_d   = div_factor_o;
    case (state_q)
      IDLE: begin
        if (target != freq_sel_o) begin
          state_d = WAIT;
          busy_d  = 1'b1;
          tmo_d   = '0;
        end
      end
      WAIT: begin
        tmo_d = tmo_q + 1'b1;
        // A revert wins over a coincident boundary.
        if (target == freq_sel_o) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end else if (period_end_i || (tmo_q == tmo_last_lp)) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          load_d  = 1'b1;
          sel_d   = target;
          div_d   = target ? div_high_p : div_low_p;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      tmo_q        <= '0;
      busy_o       <= 1'b0;
      load_o       <= 1'b0;
      freq_sel_o   <= 1'b0;
      div_factor_o <= div_low_p;
    end else begin
      state_q      <= state_d;
      tmo_q        <= tmo_d;
      busy_o       <= busy_d;
      load_o       <= load_d;
      freq_sel_o   <= sel_d;
      div_factor_o <= div_d;
    end
  end

endmodule

// File: tb/tb_freq_select_conditioner.sv
// tb/tb_freq_select_conditioner.sv - directed vector bench for freq_select_conditioner
module tb_freq_select_conditioner;

  localparam logic [31:0] LO = 32'd389120;
  localparam logic [31:0] HI = 32'd110592;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sw_i = 1'b0;
  logic        period_end_i = 1'b0;
  logic [31:0] div_factor_o;
  logic        freq_sel_o;
  logic        load_o;
  logic        busy_o;

  int n_tests = 0;
  int n_fail  = 0;
  int mon_err = 0;

  freq_select_conditioner #(
    .sync_stages_p(2),
    .debounce_cycles_p(16),
    .timeout_cycles_p(64),
    .div_width_p(32)
  ) dut (
    .clk(clk),
    .rst(rst),
    .sw_i(sw_i),
    .period_end_i(period_end_i),
    .div_factor_o(div_factor_o),
    .freq_sel_o(freq_sel_o),
    .load_o(load_o),
    .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        sw;
    logic        pe;
    int          n;
    logic        busy;
    logic        load;
    logic        sel;
    logic [31:0] div;
  } vec_t;

  vec_t vecs[18];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Load strobes must be isolated and the factor may only move with a strobe.
  logic        prev_load = 1'b0;
  logic        prev_rst  = 1'b1;
  logic [31:0] prev_div  = LO;
  always @(negedge clk) begin
    if (!rst && !prev_rst) begin
      if (load_o && prev_load) mon_err++;
      if (!load_o && div_factor_o !== prev_div) mon_err++;
    end
    prev_load = load_o;
    prev_rst  = rst;
    prev_div  = div_factor_o;
  end

  initial begin
    int k;
    //          rst sw pe  n  busy load sel div
    vecs[0]  = '{1, 0, 0,  3, 0, 0, 0, LO};
    vecs[1]  = '{0, 1, 0, 10, 0, 0, 0, LO};
    vecs[2]  = '{0, 0, 0, 30, 0, 0, 0, LO};
    vecs[3]  = '{0, 1, 0, 19, 1, 0, 0, LO};
    vecs[4]  = '{0, 1, 1,  1, 0, 1, 1, HI};
    vecs[5]  = '{0, 1, 0,  1, 0, 0, 1, HI};
    vecs[6]  = '{0, 0, 0, 19, 1, 0, 1, HI};
    vecs[7]  = '{0, 1, 0, 18, 1, 0, 1, HI};
    vecs[8]  = '{0, 1, 1,  1, 0, 0, 1, HI};
    vecs[9]  = '{0, 1, 1,  1, 0, 0, 1, HI};
    vecs[10] = '{0, 0, 0, 19, 1, 0, 1, HI};
    vecs[11] = '{0, 0, 0, 63, 1, 0, 1, HI};
    vecs[12] = '{0, 0, 0,  1, 0, 1, 0, LO};
    vecs[13] = '{0, 0, 0,  1, 0, 0, 0, LO};
    vecs[14] = '{0, 1, 0, 19, 1, 0, 0, LO};
    vecs[15] = '{1, 1, 0,  1, 0, 0, 0, LO};
    vecs[16] = '{0, 0, 1,  1, 0, 0, 0, LO};
    vecs[17] = '{0, 0, 0, 30, 0, 0, 0, LO};

    for (int i = 0; i < 18; i++) begin
      rst          = vecs[i].rst;
      sw_i         = vecs[i].sw;
      period_end_i = vecs[i].pe;
      tick();
      period_end_i = 1'b0;
      for (int j = 1; j < vecs[i].n; j++) tick();
      check($sformatf("v%0d.busy", i), 32'(busy_o), 32'(vecs[i].busy));
      check($sformatf("v%0d.load", i), 32'(load_o), 32'(vecs[i].load));
      check($sformatf("v%0d.sel", i), 32'(freq_sel_o), 32'(vecs[i].sel));
      check($sformatf("v%0d.div", i), div_factor_o, vecs[i].div);
    end

    // Exact debounce latency, then forced load after the timeout.
    sw_i = 1'b1;
    k = 0;
    while (!busy_o && k < 100) begin
      tick();
      k++;
    end
    check("busy_latency", k, 19);
    k = 0;
    while (!load_o && k < 200) begin
      tick();
      k++;
    end
    check("timeout_latency", k, 64);
    check("timeout_div", div_factor_o, HI);
    check("timeout_sel", 32'(freq_sel_o), 32'd1);
    tick();
    check("timeout_load_clr", 32'(load_o), 32'd0);

    // Boundary-driven load five cycles after busy.
    sw_i = 1'b0;
    k = 0;
    while (!busy_o && k < 100) begin
      tick();
      k++;
    end
    check("busy_latency2", k, 19);
    repeat (5) tick();
    check("pe_wait_load", 32'(load_o), 32'd0);
    period_end_i = 1'b1;
    tick();
    period_end_i = 1'b0;
    check("pe_load", 32'(load_o), 32'd1);
    check("pe_div", div_factor_o, LO);
    check("pe_busy", 32'(busy_o), 32'd0);
    tick();
    check("pe_load_clr", 32'(load_o), 32'd0);

    check("monitor", mon_err, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
